// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with optional skid entry and decoded instruction fields.
// Macro PIPE_SKID_STAGE_SKID_EN adds the skid entry and a registered in_ready.
module pipe_skid_stage #(
    parameter int unsigned SIDE_W   = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_pc,
    input  logic [15:0]       in_ir,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_pc,
    output logic [15:0]       out_ir,
    output logic [3:0]        out_opcode,
    output logic [2:0]        out_dest,
    output logic [2:0]        out_src1,
    output logic [2:0]        out_src2,
    output logic              out_ir5,
    output logic              out_ir11,
    output logic [SIDE_W-1:0] out_side,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [15:0]       main_pc_q, main_pc_d;
    logic [15:0]       main_ir_q, main_ir_d;
    logic [SIDE_W-1:0] main_side_q, main_side_d;
    logic              accept_s;
    logic              drain_s;

    assign accept_s = in_valid && in_ready;
    assign drain_s  = main_valid_q && out_ready;

`ifdef PIPE_SKID_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [15:0]       skid_pc_q, skid_pc_d;
    logic [15:0]       skid_ir_q, skid_ir_d;
    logic [SIDE_W-1:0] skid_side_q, skid_side_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready  = in_ready_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    // Next-state: a held skid entry refills main before any new input is taken.
    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_ir_d    = main_ir_q;
        main_side_d  = main_side_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_ir_d    = skid_ir_q;
        skid_side_d  = skid_side_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain_s) begin
                main_pc_d    = skid_pc_q;
                main_ir_d    = skid_ir_q;
                main_side_d  = skid_side_q;
                skid_valid_d = 1'b0;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end else if (accept_s) begin
            if (!main_valid_q || drain_s) begin
                main_valid_d = 1'b1;
                main_pc_d    = in_pc;
                main_ir_d    = in_ir;
                main_side_d  = in_side;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = in_pc;
                skid_ir_d    = in_ir;
                skid_side_d  = in_side;
            end
        end else if (drain_s) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_valid_q;
        end
        in_ready_d = !skid_valid_d;
    end

    // Skid entry and registered ready; payload survives flush, only valid clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 16'h0000;
            skid_ir_q    <= 16'h0000;
            skid_side_q  <= {SIDE_W{1'b0}};
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_ir_q    <= skid_ir_d;
            skid_side_q  <= skid_side_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready  = !main_valid_q || out_ready;
    assign occupancy = {1'b0, main_valid_q};

    // Next-state for the single entry: load on accept, empty on drain.
    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_ir_d    = main_ir_q;
        main_side_d  = main_side_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept_s) begin
            main_valid_d = 1'b1;
            main_pc_d    = in_pc;
            main_ir_d    = in_ir;
            main_side_d  = in_side;
        end else if (drain_s) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_valid_q;
        end
    end
`endif

    // Main entry drives the outputs directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= RESET_PC;
            main_ir_q    <= 16'h0000;
            main_side_q  <= {SIDE_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_ir_q    <= main_ir_d;
            main_side_q  <= main_side_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_pc     = main_pc_q;
    assign out_ir     = main_ir_q;
    assign out_side   = main_side_q;
    assign out_opcode = main_ir_q[15:12];
    assign out_dest   = main_ir_q[11:9];
    assign out_src1   = main_ir_q[8:6];
    assign out_src2   = main_ir_q[2:0];
    assign out_ir5    = main_ir_q[5];
    assign out_ir11   = main_ir_q[11];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_pipe_skid_stage;

    localparam logic [15:0] RST_PC = 16'hA5A0;
`ifdef PIPE_SKID_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
    localparam int CAP  = 2;
`else
    localparam bit SKID = 1'b0;
    localparam int CAP  = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_pc, in_ir, out_pc, out_ir;
    logic [7:0]  in_side, out_side;
    logic [3:0]  out_opcode;
    logic [2:0]  out_dest, out_src1, out_src2;
    logic        out_ir5, out_ir11;
    logic [1:0]  occupancy;

    pipe_skid_stage #(.SIDE_W(8), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_opcode(out_opcode),
        .out_dest(out_dest), .out_src1(out_src1), .out_src2(out_src2),
        .out_ir5(out_ir5), .out_ir11(out_ir11),
        .out_side(out_side), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [7:0]  side;
    } ent_t;

    ent_t mq[$];
    bit   m_on  = 1'b0;
    bit   m_rst = 1'b0;
    bit   m_acc = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stage may take an input if it has room, or (single entry) if the held one leaves now.
    function automatic bit model_ready();
        return (mq.size() < CAP) || (!SKID && out_ready);
    endfunction

    task automatic model_step();
        bit   rdy;
        ent_t e;
        rdy   = model_ready();
        m_acc = 1'b0;
        if (reset) begin
            mq.delete();
            m_rst = 1'b1;
            m_on  = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_rst = 1'b0;
        end else begin
            m_rst = 1'b0;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
                e.pc = in_pc; e.ir = in_ir; e.side = in_side;
                mq.push_back(e);
                m_acc = 1'b1;
            end
        end
    endtask

    // One clock: apply inputs, update model at the edge, return just after it.
    task automatic cyc(input bit iv, input logic [15:0] ir, input bit ordy, input bit fl, input bit rs);
        in_valid  = iv;
        in_ir     = ir;
        in_pc     = ir ^ 16'h3C3C;
        in_side   = ir[7:0] ^ ir[15:8];
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("occupancy", occupancy, mq.size());
            chk("in_ready", in_ready, model_ready());
            if (mq.size() > 0) begin
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_ir", out_ir, mq[0].ir);
                chk("out_side", out_side, mq[0].side);
                chk("out_opcode", out_opcode, mq[0].ir >> 12);
                chk("out_dest", out_dest, (mq[0].ir >> 9) & 16'h0007);
                chk("out_src1", out_src1, (mq[0].ir >> 6) & 16'h0007);
                chk("out_src2", out_src2, mq[0].ir & 16'h0007);
                chk("out_ir5", out_ir5, (mq[0].ir >> 5) & 16'h0001);
                chk("out_ir11", out_ir11, (mq[0].ir >> 11) & 16'h0001);
            end else if (m_rst) begin
                chk("rst_out_pc", out_pc, RST_PC);
                chk("rst_out_ir", out_ir, 32'h0);
                chk("rst_out_side", out_side, 32'h0);
            end
        end
    end

    initial begin
        logic [15:0] w3;
        bit          done;
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", out_valid, 32'h0);
        chk("reset_occ", occupancy, 32'h0);
        chk("reset_ready", in_ready, 32'h1);
        chk("reset_pc", out_pc, RST_PC);
        chk("reset_ir", out_ir, 32'h0);
        chk("reset_side", out_side, 32'h0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Streaming with four LC-3b words.
        cyc(1'b1, 16'h1283, 1'b1, 1'b0, 1'b0);
        chk("stream0_valid", out_valid, 32'h1);
        chk("stream0_ir", out_ir, 32'h1283);
        chk("stream0_opcode", out_opcode, 32'h1);
        chk("stream0_dest", out_dest, 32'h1);
        chk("stream0_src1", out_src1, 32'h2);
        chk("stream0_src2", out_src2, 32'h3);
        chk("stream0_pc", out_pc, 32'h2EBF);
        cyc(1'b1, 16'h5A25, 1'b1, 1'b0, 1'b0);
        chk("stream1_ir", out_ir, 32'h5A25);
        chk("stream1_ir5", out_ir5, 32'h1);
        chk("stream1_ir11", out_ir11, 32'h1);
        cyc(1'b1, 16'h0E02, 1'b1, 1'b0, 1'b0);
        chk("stream2_ir", out_ir, 32'h0E02);
        cyc(1'b1, 16'hC1C0, 1'b1, 1'b0, 1'b0);
        chk("stream3_ir", out_ir, 32'hC1C0);
        chk("stream3_opcode", out_opcode, 32'hC);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("stream_drained", out_valid, 32'h0);

        // Stall: three offers with the consumer blocked.
        cyc(1'b1, 16'h2001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h2002, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h2003, 1'b0, 1'b0, 1'b0);
        chk("stall_occ", occupancy, CAP);
        chk("stall_ready", in_ready, 32'h0);
        chk("stall_head", out_ir, 32'h2001);
        out_ready = 1'b1;
        #1;
        chk("stall_ready_follows", in_ready, !SKID);
        w3   = 16'h2003;
        done = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            cyc(1'b1, w3, 1'b1, 1'b0, 1'b0);
            done = m_acc;
        end
        chk("stall_third_taken", done, 32'h1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("stall_drained", out_valid, 32'h0);

        // Flush with a full stage and a concurrent input.
        cyc(1'b1, 16'h3001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h3002, 1'b0, 1'b0, 1'b0);
        chk("preflush_occ", occupancy, CAP);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", out_valid, 32'h0);
        chk("flush_occ", occupancy, 32'h0);
        chk("flush_ready", in_ready, 32'h1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("flush_nothing_out", out_valid, 32'h0);

        // Reset mid-stall.
        cyc(1'b1, 16'h4001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h4002, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("rststall_valid", out_valid, 32'h0);
        chk("rststall_pc", out_pc, RST_PC);
        chk("rststall_ir", out_ir, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("rststall_nothing_out", out_valid, 32'h0);

        // Flush and reset together.
        cyc(1'b1, 16'h5001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h5002, 1'b0, 1'b1, 1'b1);
        chk("flushrst_valid", out_valid, 32'h0);
        chk("flushrst_pc", out_pc, RST_PC);
        chk("flushrst_ir", out_ir, 32'h0);

        // Drain with a concurrent offer while full.
        cyc(1'b1, 16'h6001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h6002, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("move_ready", in_ready, !SKID);
        cyc(1'b1, 16'h6003, 1'b1, 1'b0, 1'b0);
        chk("move_head", out_ir, SKID ? 32'h6002 : 32'h6003);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("final_empty", out_valid, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter SIDE_W, default 8, width of the sideband control payload carried alongside the instruction.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, value driven on out_pc while in reset.
REQ-003 SHALL run on one clock with a synchronous, active-high reset; ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high; clears all state.
REQ-006 flush  input  1  squash all held entries; branch mispredict or trap redirect.
REQ-007 in_valid  input  1  upstream stage presents an instruction.
REQ-008 in_ready  output  1  stage accepts the presented instruction this cycle.
REQ-009 in_pc  input  16  PC+2 of the instruction.
REQ-010 in_ir  input  16  raw LC-3b instruction word.
REQ-011 in_side  input  SIDE_W  sideband control bits.
REQ-012 out_valid  output  1  held instruction is valid.
REQ-013 out_ready  input  1  downstream stage consumes the instruction this cycle.
REQ-014 out_pc, out_ir  output  16 each  held PC+2 and instruction word.
REQ-015 out_opcode  output  4  out_ir[15:12].
REQ-016 out_dest, out_src1, out_src2  output  3 each  out_ir[11:9], out_ir[8:6], out_ir[2:0].
REQ-017 out_ir5, out_ir11  output  1 each  out_ir[5], out_ir[11].
REQ-018 out_side  output  SIDE_W  held sideband bits.
REQ-019 occupancy  output  2  number of valid entries held (0..2).

Function
REQ-020 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-021 Latency SHALL be one cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1 when the stage was empty.
REQ-022 Storage SHALL be a main entry driving the outputs plus one skid entry; entries SHALL leave in acceptance order.
REQ-023 in_ready SHALL be a registered signal, equal to NOT skid-entry-valid; it SHALL never depend combinationally on out_ready.
REQ-024 Accept while the main entry is empty, or is full and draining: data goes to the main entry.
REQ-025 Accept while the main entry is full and not draining: data goes to the skid entry.
REQ-026 Main entry drains while the skid entry is valid: the skid moves to main in the same edge and the skid empties; a same-cycle accept is impossible (in_ready=0).
REQ-027 While out_valid && !out_ready, all out_* fields SHALL hold stable.
REQ-028 Decoded fields SHALL be pure slices of the stored out_ir; no separate decode registers.
REQ-029 flush SHALL clear both valid bits at the next edge; an input presented in the flush cycle SHALL be discarded; in_ready SHALL be 1 in the cycle after the flush.
REQ-030 Payload registers SHALL keep their contents on flush; only the valid bits clear.
REQ-031 occupancy SHALL equal main-valid + skid-valid after every edge.
REQ-032 Throughput SHALL be one instruction per cycle while out_ready stays high.

Reset
REQ-033 reset SHALL take priority over flush and over all transfers.
REQ-034 While reset is asserted, the outputs SHALL be: out_valid=0, occupancy=0, in_ready=1, out_ir=16'h0000, out_side=0, out_pc=RESET_PC.
REQ-035 Reset asserted mid-stall SHALL discard both entries; no entry SHALL be emitted after the reset is released.

Configuration
REQ-036 Macro PIPE_SKID_STAGE_SKID_EN defined: the two-entry behaviour of REQ-022 to REQ-026 applies.
REQ-037 Macro undefined: the skid entry is removed, in_ready = !out_valid || out_ready (combinational), and occupancy never exceeds 1; all other requirements still apply.

Verification
REQ-038 Streaming: out_ready=1, in_valid=1 for 4 cycles with in_ir=16'h1283,16'h5A25,16'h0E02,16'hC1C0 -> the same words appear on out_ir in order, one per cycle, on cycles N+1..N+4. For 16'h1283, out_opcode=4'h1, out_dest=1, out_src1=2, out_src2=3.
REQ-039 Stall: out_ready=0, 3 instructions offered -> 2 accepted, occupancy=2, in_ready=0 from the 3rd cycle. Then out_ready=1 -> the first two drain in order and the third is accepted.
REQ-040 Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, and the flushed-cycle input never appears.
REQ-041 Reset mid-stall: occupancy=2, reset=1 for 1 cycle -> out_valid=0, out_pc=RESET_PC, out_ir=0.
REQ-042 Simultaneous events: flush and reset asserted together -> reset values. Skid-to-main move with a concurrent in_valid -> the input is not accepted (in_ready=0).
REQ-043 With PIPE_SKID_STAGE_SKID_EN undefined: rerun REQ-039 -> occupancy peaks at 1, and in_ready follows out_ready in the same cycle.
